// File: rtl/peripheral_uart_rfifo_wb.sv
// UART receiver FIFO: 16-deep character store with overrun, trigger level and
// per-entry error tracking. Optional feature macro: PERIPHERAL_UART_RFIFO_ERROR_TRACK_EN.
module peripheral_uart_rfifo_wb #(
    parameter int FIFO_WIDTH     = 11,
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_POINTER_W = 4,
    parameter int FIFO_COUNTER_W = 5
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic                      push,
    input  logic                      pop,
    input  logic [FIFO_WIDTH-1:0]     data_in,
    input  logic                      fifo_reset,
    input  logic                      reset_status,
    input  logic [1:0]                rx_trigger_sel,
    output logic [FIFO_WIDTH-1:0]     data_out,
    output logic                      overrun,
    output logic [FIFO_COUNTER_W-1:0] count,
    output logic                      error_bit,
    output logic                      trigger
);

`ifdef PERIPHERAL_UART_RFIFO_ERROR_TRACK_EN
    localparam int STORE_W = FIFO_WIDTH;
`else
    localparam int STORE_W = 8;
`endif

    localparam logic [FIFO_COUNTER_W-1:0] DEPTH_C    = FIFO_COUNTER_W'(FIFO_DEPTH);
    localparam logic [FIFO_POINTER_W-1:0] PTR_LAST_C = FIFO_POINTER_W'(FIFO_DEPTH - 1);

    logic [STORE_W-1:0]        mem_r [FIFO_DEPTH];
    logic [FIFO_POINTER_W-1:0] wr_ptr_r;
    logic [FIFO_POINTER_W-1:0] rd_ptr_r;
    logic [FIFO_COUNTER_W-1:0] count_r;
    logic                      overrun_r;
    logic [FIFO_COUNTER_W-1:0] count_nxt_s;
    logic [FIFO_COUNTER_W-1:0] trig_lvl_s;
    logic                      empty_s;
    logic                      full_s;
    logic                      wr_en_s;
    logic                      rd_en_s;
    logic                      ovf_s;

    function automatic logic [FIFO_POINTER_W-1:0] ptr_inc(input logic [FIFO_POINTER_W-1:0] p);
        if (p == PTR_LAST_C) begin
            return {FIFO_POINTER_W{1'b0}};
        end else begin
            return p + FIFO_POINTER_W'(1);
        end
    endfunction

    // Decode push/pop against occupancy; a pop of an empty FIFO is dropped, and
    // a push while full is accepted only when a pop frees the head slot.
    always_comb begin
        empty_s = (count_r == {FIFO_COUNTER_W{1'b0}});
        full_s  = (count_r == DEPTH_C);
        rd_en_s = pop && !empty_s;
        wr_en_s = push && (!full_s || pop);
        ovf_s   = push && full_s && !pop;
    end

    // Next occupancy value.
    always_comb begin
        count_nxt_s = count_r;
        if (wr_en_s && !rd_en_s) begin
            count_nxt_s = count_r + FIFO_COUNTER_W'(1);
        end else if (rd_en_s && !wr_en_s) begin
            count_nxt_s = count_r - FIFO_COUNTER_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, occupancy and sticky overrun; any clear beats a same-cycle overflow.
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            wr_ptr_r  <= {FIFO_POINTER_W{1'b0}};
            rd_ptr_r  <= {FIFO_POINTER_W{1'b0}};
            count_r   <= {FIFO_COUNTER_W{1'b0}};
            overrun_r <= 1'b0;
        end else if (fifo_reset) begin
            wr_ptr_r  <= {FIFO_POINTER_W{1'b0}};
            rd_ptr_r  <= {FIFO_POINTER_W{1'b0}};
            count_r   <= {FIFO_COUNTER_W{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_en_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_nxt_s;
            if (reset_status) begin
                overrun_r <= 1'b0;
            end else if (ovf_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    // Character storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en_s && !fifo_reset && !wb_rst_i) begin
            mem_r[wr_ptr_r] <= data_in[STORE_W-1:0];
        end
    end

`ifdef PERIPHERAL_UART_RFIFO_ERROR_TRACK_EN
    logic [FIFO_DEPTH-1:0] err_flag_r;

    // Per-entry error flag; the write is ordered last so it wins when the
    // popped slot is rewritten in the same cycle.
    always_ff @(posedge clk) begin
        if (wb_rst_i || fifo_reset) begin
            err_flag_r <= {FIFO_DEPTH{1'b0}};
        end else begin
            if (rd_en_s) begin
                err_flag_r[rd_ptr_r] <= 1'b0;
            end
            if (wr_en_s) begin
                err_flag_r[wr_ptr_r] <= |data_in[10:8];
            end
        end
    end

    assign error_bit = |err_flag_r;
`else
    logic unused_err_s;
    assign unused_err_s = ^data_in[FIFO_WIDTH-1:STORE_W];
    assign error_bit    = 1'b0;
`endif

    // Head entry, zeroed while empty.
    always_comb begin
        data_out = {FIFO_WIDTH{1'b0}};
        if (!empty_s) begin
            data_out = FIFO_WIDTH'(mem_r[rd_ptr_r]);
        end else begin
            data_out = {FIFO_WIDTH{1'b0}};
        end
    end

    // Trigger level decode.
    always_comb begin
        trig_lvl_s = FIFO_COUNTER_W'(1);
        case (rx_trigger_sel)
            2'b00:   trig_lvl_s = FIFO_COUNTER_W'(1);
            2'b01:   trig_lvl_s = FIFO_COUNTER_W'(4);
            2'b10:   trig_lvl_s = FIFO_COUNTER_W'(8);
            2'b11:   trig_lvl_s = FIFO_COUNTER_W'(14);
            default: trig_lvl_s = FIFO_COUNTER_W'(1);
        endcase
        trigger = (count_r >= trig_lvl_s);
    end

    assign count   = count_r;
    assign overrun = overrun_r;

endmodule
